// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the front-end pipeline
package pipe_pkg;

  localparam int AW_DEF  = 8;
  localparam int IW_DEF  = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 8;

  localparam logic [IW_DEF-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry skid register for a word fetched during a stall
module fetch_hold_buf #(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic          unload,
  input  logic [IW-1:0] load_data,
  input  logic [AW-1:0] load_npc,
  output logic [IW-1:0] data,
  output logic [AW-1:0] npc,
  output logic          full
);

  // clear wins over load so a redirect always leaves the buffer empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      npc  <= '0;
      full <= 1'b0;
    end else if (clear) begin
      data <= '0;
      npc  <= '0;
      full <= 1'b0;
    end else if (load) begin
      data <= load_data;
      npc  <= load_npc;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, program-memory handshake, CCG1 segment feed
module fetch_stage #(
  parameter int            AW       = 8,
  parameter int            IW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [IW-1:0] NOP_WORD = IW'(pipe_pkg::NOP_WORD)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          l_pc,
  input  logic [AW-1:0] pc_target,
  input  logic          stall,
  output logic [IW-1:0] segment,
  output logic [AW-1:0] npc,
  output logic          seg_valid
);
  import pipe_pkg::*;

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pend_q, pend_d;
  logic [IW-1:0] seg_q, seg_d;
  logic [AW-1:0] npc_q, npc_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] pc_inc;

  logic          hb_load, hb_clear, hb_unload;
  logic [IW-1:0] hb_data;
  logic [AW-1:0] hb_npc;
  logic          hb_full;

  assign pc_inc    = pc_q + AW'(1);
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign segment   = seg_q;
  assign npc       = npc_q;
  assign seg_valid = valid_q;

  fetch_hold_buf #(
    .AW(AW),
    .IW(IW)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hb_load),
    .clear    (hb_clear),
    .unload   (hb_unload),
    .load_data(imem_rdata),
    .load_npc (pc_inc),
    .data     (hb_data),
    .npc      (hb_npc),
    .full     (hb_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      seg_q   <= NOP_WORD;
      npc_q   <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    seg_d     = seg_q;
    npc_d     = npc_q;
    valid_d   = valid_q;
    hb_load   = 1'b0;
    hb_clear  = 1'b0;
    hb_unload = 1'b0;

    if (l_pc) begin
      seg_d    = NOP_WORD;
      valid_d  = 1'b0;
      npc_d    = pc_target;
      hb_clear = 1'b1;
      case (state_q)
        // imem_addr must not move under an open request, so the target waits in pend
        S_FETCH, S_DRAIN: begin
          if (imem_ack) begin
            pc_d    = pc_target;
            state_d = stall ? S_IDLE : S_FETCH;
          end else begin
            pend_d  = pc_target;
            state_d = S_DRAIN;
          end
        end
        default: begin
          pc_d    = pc_target;
          state_d = stall ? S_IDLE : S_FETCH;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!stall) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            if (!stall) begin
              seg_d   = imem_rdata;
              npc_d   = pc_inc;
              valid_d = 1'b1;
            end else begin
              hb_load = 1'b1;
              state_d = S_HOLD;
            end
          end else if (!stall) begin
            seg_d   = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            hb_unload = 1'b1;
            seg_d     = hb_data;
            npc_d     = hb_npc;
            valid_d   = hb_full;
            state_d   = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            seg_d   = NOP_WORD;
            valid_d = 1'b0;
          end
          if (imem_ack) begin
            pc_d    = pend_q;
            state_d = stall ? S_IDLE : S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        l_pc;
  logic [7:0]  pc_target;
  logic        stall;
  logic [15:0] segment;
  logic [7:0]  npc;
  logic        seg_valid;

  logic [15:0] mem [256];

  typedef struct packed {
    logic [15:0] seg;
    logic [7:0]  npc;
  } sb_t;

  typedef struct packed {
    logic        stall;
    logic        ack;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic [15:0] exp_seg;
    logic [7:0]  exp_npc;
    logic        exp_valid;
  } vec_t;

  sb_t  sb_q[$];
  bit   sb_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tbl [12];

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .l_pc      (l_pc),
    .pc_target (pc_target),
    .stall     (stall),
    .segment   (segment),
    .npc       (npc),
    .seg_valid (seg_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic a, input logic l, input logic [7:0] t);
    stall     = s;
    imem_ack  = a;
    l_pc      = l;
    pc_target = t;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_seg"},   32'(segment),   32'h0000);
    chk({tag, "_npc"},   32'(npc),       32'h00);
    chk({tag, "_valid"}, 32'(seg_valid), 32'h0);
    chk({tag, "_req"},   32'(imem_req),  32'h0);
    chk({tag, "_addr"},  32'(imem_addr), 32'h00);
  endtask

  // every cycle with a valid segment while enabled must match the oldest expectation
  always @(negedge clk) begin
    if (sb_en && rst_n && seg_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h/%h with nothing expected", segment, npc);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_seg", 32'(segment), 32'(e.seg));
        chk("sb_npc", 32'(npc), 32'(e.npc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hA0 ^ i[7:0], i[7:0]};
    mem[0] = 16'h5B01;
    mem[1] = 16'h0000;
    mem[2] = 16'h8802;

    // stall  ack  req  addr   seg       npc    valid
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h03, 16'h0000, 8'h03, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h03, 16'h0000, 8'h03, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h03, 16'hA303, 8'h04, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h04, 16'hA303, 8'h04, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h05, 16'hA303, 8'h04, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h05, 16'hA303, 8'h04, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h05, 16'hA303, 8'h04, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h05, 16'hA404, 8'h05, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h05, 16'hA505, 8'h06, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h06, 16'hA505, 8'h06, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h06, 16'h0000, 8'h06, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h06, 16'hA606, 8'h07, 1'b1};

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    check_reset("rst_init");
    rst_n = 1'b1;

    // streaming from reset with ack tied high
    chk("s1_idle_req", 32'(imem_req), 32'h0);
    set_in(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    sb_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("s1_req%0d", k), 32'(imem_req), 32'h1);
      chk($sformatf("s1_addr%0d", k), 32'(imem_addr), 32'(k));
      sb_q.push_back({mem[k], 8'(k + 1)});
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s1_addr3", 32'(imem_addr), 32'h03);
    tick();
    sb_en = 1'b0;
    chk("s1_sb_empty", 32'(sb_q.size()), 32'h0);

    // delayed ack and stall-in-ack-cycle sequences
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].stall, tbl[i].ack, 1'b0, 8'h00);
      chk($sformatf("t%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
      chk($sformatf("t%0d_addr", i), 32'(imem_addr), 32'(tbl[i].exp_addr));
      tick();
      chk($sformatf("t%0d_seg", i), 32'(segment), 32'(tbl[i].exp_seg));
      chk($sformatf("t%0d_npc", i), 32'(npc), 32'(tbl[i].exp_npc));
      chk($sformatf("t%0d_valid", i), 32'(seg_valid), 32'(tbl[i].exp_valid));
    end

    // redirect while the request to 07 is outstanding
    set_in(1'b0, 1'b0, 1'b1, 8'h40);
    chk("rd_addr_pre", 32'(imem_addr), 32'h07);
    tick();
    chk("rd_seg", 32'(segment), 32'h0000);
    chk("rd_valid", 32'(seg_valid), 32'h0);
    chk("rd_npc", 32'(npc), 32'h40);
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rd_drain_req", 32'(imem_req), 32'h1);
    chk("rd_drain_addr", 32'(imem_addr), 32'h07);
    tick();
    chk("rd_drain_valid", 32'(seg_valid), 32'h0);
    set_in(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rd_drain_addr2", 32'(imem_addr), 32'h07);
    tick();
    chk("rd_drop_valid", 32'(seg_valid), 32'h0);
    chk("rd_drop_seg", 32'(segment), 32'h0000);
    sb_en = 1'b1;
    chk("rd_new_req", 32'(imem_req), 32'h1);
    chk("rd_new_addr", 32'(imem_addr), 32'h40);
    sb_q.push_back({mem[8'h40], 8'h41});
    tick();

    // redirect coinciding with ack, then the PC wrap
    set_in(1'b0, 1'b1, 1'b1, 8'hFE);
    chk("ra_addr", 32'(imem_addr), 32'h41);
    tick();
    chk("ra_valid", 32'(seg_valid), 32'h0);
    chk("ra_npc", 32'(npc), 32'hFE);
    set_in(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wr_addr_fe", 32'(imem_addr), 32'hFE);
    sb_q.push_back({mem[8'hFE], 8'hFF});
    tick();
    chk("wr_addr_ff", 32'(imem_addr), 32'hFF);
    sb_q.push_back({mem[8'hFF], 8'h00});
    tick();
    chk("wr_npc", 32'(npc), 32'h00);
    chk("wr_addr_00", 32'(imem_addr), 32'h00);
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    sb_en = 1'b0;
    chk("rd_sb_empty", 32'(sb_q.size()), 32'h0);

    // asynchronous reset while holding a stalled word
    set_in(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    chk("rh_hold_req", 32'(imem_req), 32'h0);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_hold");
    #1 rst_n = 1'b1;
    tick();
    set_in(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rh_idle_req", 32'(imem_req), 32'h0);
    tick();
    chk("rh_req", 32'(imem_req), 32'h1);
    chk("rh_addr", 32'(imem_addr), 32'h00);
    tick();
    chk("rh_seg", 32'(segment), 32'h5B01);
    chk("rh_npc", 32'(npc), 32'h01);
    chk("rh_valid", 32'(seg_valid), 32'h1);

    // asynchronous reset while draining, after the pending target is overwritten
    set_in(1'b0, 1'b0, 1'b1, 8'h20);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 8'h30);
    chk("rdr_addr", 32'(imem_addr), 32'h01);
    tick();
    chk("rdr_npc", 32'(npc), 32'h30);
    chk("rdr_addr2", 32'(imem_addr), 32'h01);
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_drain");
    #1 rst_n = 1'b1;
    tick();
    chk("rdr_restart_req", 32'(imem_req), 32'h1);
    chk("rdr_restart_addr", 32'(imem_addr), 32'h00);
    set_in(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    chk("rdr_seg", 32'(segment), 32'h5B01);
    chk("rdr_npc", 32'(npc), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
